// File: rtl/alu_exec_ctrl.sv
// ============================================================================
//  Module      : alu_exec_ctrl
//  Description : Serial execution controller sitting in front of a 4-bit
//                combinational ALU. Owns a 4 x 4-bit register file, accepts
//                one instruction per valid/ready handshake, drives the ALU
//                operands/opcode from registers, writes the ALU result back
//                and reports each retired result as a one-cycle pulse.
//
//  Ports
//    clk, rst            : clock, synchronous active-high reset
//    instr_valid/ready   : instruction handshake
//    instr_op/dst/sa/sb  : opcode, destination and source register indices
//    instr_imm_en/imm    : immediate replaces operand B when enabled
//    A, B, Op            : registered ALU operands and opcode
//    R                   : ALU result (combinational from A, B, Op)
//    res_valid           : one-cycle retire pulse
//    res_data/dst/zero   : retired result, its destination, zero flag
//    dbg_addr/dbg_data   : combinational register-file read port
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_ctrl #(
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [1:0] instr_dst,
    input  logic [1:0] instr_sa,
    input  logic [1:0] instr_sb,
    input  logic       instr_imm_en,
    input  logic [3:0] instr_imm,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] Op,
    input  logic [3:0] R,
    output logic       res_valid,
    output logic [3:0] res_data,
    output logic [1:0] res_dst,
    output logic       res_zero,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_WB   = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_regs [0:3];
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [2:0] r_op;
    logic [1:0] r_dst;
    logic       r_res_valid;
    logic [3:0] r_res_data;
    logic [1:0] r_res_dst;
    logic       r_res_zero;

    logic       w_accept;
    logic [3:0] w_operand_b;

    assign instr_ready = (r_state == c_S_IDLE);
    assign w_accept    = instr_ready && instr_valid;
    assign w_operand_b = instr_imm_en ? instr_imm : r_regs[instr_sb];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_a         <= 4'h0;
            r_b         <= 4'h0;
            r_op        <= 3'b000;
            r_dst       <= 2'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 4'h0;
            r_res_dst   <= 2'd0;
            r_res_zero  <= 1'b1;
        end else begin
            // Pulse: cleared every cycle unless WB sets it below.
            r_res_valid <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= r_regs[instr_sa];
                        r_b     <= w_operand_b;
                        r_op    <= instr_op;
                        r_dst   <= instr_dst;
                        r_state <= c_S_EXEC;
                    end
                end
                c_S_EXEC: begin
                    // One cycle for the external ALU path to settle.
                    r_state <= c_S_WB;
                end
                c_S_WB: begin
                    r_regs[r_dst] <= R;
                    r_res_data    <= R;
                    r_res_dst     <= r_dst;
                    r_res_zero    <= (R == 4'h0);
                    r_res_valid   <= 1'b1;
                    r_state       <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign Op        = r_op;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_dst   = r_res_dst;
    assign res_zero  = r_res_zero;

    // Reads the pre-edge contents, so a same-cycle WB write shows up next cycle.
    assign dbg_data  = r_regs[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
// ============================================================================
//  Module      : tb_alu_exec_ctrl
//  Description : Self-checking bench for alu_exec_ctrl. Provides the 4-bit
//                ALU, drives a vector table plus hand-written sequences and
//                checks retired results through an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_dst;
    logic [1:0] instr_sa;
    logic [1:0] instr_sb;
    logic       instr_imm_en;
    logic [3:0] instr_imm;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] Op;
    logic [3:0] R;
    logic       res_valid;
    logic [3:0] res_data;
    logic [1:0] res_dst;
    logic       res_zero;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    alu_exec_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_dst    (instr_dst),
        .instr_sa     (instr_sa),
        .instr_sb     (instr_sb),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .A            (A),
        .B            (B),
        .Op           (Op),
        .R            (R),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_dst      (res_dst),
        .res_zero     (res_zero),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    // The downstream combinational ALU.
    function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return ~a;
            3'b011:  return ~(a & b);
            3'b100:  return ~(a | b);
            3'b101:  return a & b;
            3'b110:  return a | b;
            default: return a ^ b;
        endcase
    endfunction
    assign R = alu(A, B, Op);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: condition not met (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard of expected retirements.
    typedef struct {
        logic [3:0] data;
        logic [1:0] dst;
        int         acc;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    logic prev_rv = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_res_valid");
                end else begin
                    mon_e = q.pop_front();
                    chk("res_data", res_data, mon_e.data);
                    chk("res_dst", res_dst, mon_e.dst);
                    chk("res_zero", res_zero, mon_e.data == 4'h0);
                    chk("latency", cyc - mon_e.acc, 2);
                end
                if (prev_rv) fail_now("res_valid_consecutive");
            end
        end
        prev_rv = res_valid;
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] dst;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       ie;
        logic [3:0] imm;
        logic [3:0] exp;
    } vec_t;

    task automatic set_fields(input vec_t v);
        instr_op     = v.op;
        instr_dst    = v.dst;
        instr_sa     = v.sa;
        instr_sb     = v.sb;
        instr_imm_en = v.ie;
        instr_imm    = v.imm;
    endtask

    // Presents an instruction, waits for the handshake, then drops valid.
    task automatic send(input vec_t v, input bit push);
        int   bound;
        exp_t e;
        @(negedge clk);
        set_fields(v);
        instr_valid = 1'b1;
        bound = 0;
        while (!instr_ready && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        if (!instr_ready) begin
            fail_now("handshake_timeout");
            instr_valid = 1'b0;
        end else begin
            if (push) begin
                e.data = v.exp;
                e.dst  = v.dst;
                e.acc  = cyc + 1;
                q.push_back(e);
            end
            @(posedge clk);
            #1 instr_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int bound = 0;
        while (q.size() != 0 && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        if (q.size() != 0) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [3:0] exp, input string nm);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                                input logic [1:0] sb, input logic ie, input logic [3:0] imm,
                                input logic [3:0] exp);
        vec_t v;
        v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.ie = ie; v.imm = imm; v.exp = exp;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        int   got;
        int   acc_c[2];
        exp_t e;

        // Arithmetic, wrap and zero cases.
        vecs[0]  = mk(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'h5, 4'h5);  // r1 = r0 + 5
        vecs[1]  = mk(3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 4'hC, 4'hC);  // r2 = r0 + 12
        vecs[2]  = mk(3'b000, 2'd3, 2'd1, 2'd2, 1'b0, 4'hF, 4'h1);  // r3 = 5 + 12 wraps
        vecs[3]  = mk(3'b001, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0, 4'h9);  // r0 = 5 - 12 wraps
        vecs[4]  = mk(3'b001, 2'd3, 2'd1, 2'd1, 1'b0, 4'h3, 4'h0);  // r3 = r1 - r1
        // Logic sweep setup: r1 = A, r2 = 6 (r3 is 0 here).
        vecs[5]  = mk(3'b000, 2'd1, 2'd3, 2'd0, 1'b1, 4'hA, 4'hA);
        vecs[6]  = mk(3'b000, 2'd2, 2'd3, 2'd0, 1'b1, 4'h6, 4'h6);
        vecs[7]  = mk(3'b010, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0, 4'h5);  // not
        vecs[8]  = mk(3'b011, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'hD);  // nand
        vecs[9]  = mk(3'b100, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0, 4'h1);  // nor
        vecs[10] = mk(3'b101, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h2);  // and
        vecs[11] = mk(3'b110, 2'd0, 2'd1, 2'd2, 1'b0, 4'h0, 4'hE);  // or
        vecs[12] = mk(3'b111, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'hC);  // xor

        rst = 1'b1;
        instr_valid = 1'b0;
        set_fields(mk(3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0));
        dbg_addr = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_zero", res_zero, 1'b1);
        chk("rst_res_data", res_data, 4'h0);
        chk("rst_abop", {A, B, Op}, 11'h0);
        for (int i = 0; i < 4; i++) rd(i[1:0], 4'h0, "rst_reg");

        // ---- arithmetic / wrap / zero ----
        for (int i = 0; i < 5; i++) send(vecs[i], 1'b1);
        wait_drain();
        rd(2'd1, 4'h5, "reg_r1_imm");
        rd(2'd0, 4'h9, "reg_r0_sub");
        rd(2'd3, 4'h0, "reg_r3_zero");

        // ---- held valid with changing fields; dst == sa ----
        got = 0;
        for (int k = 0; k < 30 && got < 2; k++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            if (instr_ready) begin
                set_fields(mk(3'b000, 2'd1, 2'd1, 2'd0, 1'b1, 4'h1, 4'h0));
                e.data = (got == 0) ? 4'h6 : 4'h7;
                e.dst  = 2'd1;
                e.acc  = cyc + 1;
                q.push_back(e);
                acc_c[got] = cyc + 1;
                got++;
            end else begin
                set_fields(mk(3'b111, 2'd2, 2'd0, 2'd3, 1'b1, 4'hF, 4'h0));
            end
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        if (got < 2) fail_now("held_valid_accepts");
        else chk("accept_spacing", acc_c[1] - acc_c[0], 3);
        wait_drain();
        rd(2'd1, 4'h7, "reg_r1_incr");
        rd(2'd2, 4'hC, "reg_r2_untouched");

        // ---- logic sweep ----
        for (int i = 5; i < 13; i++) send(vecs[i], 1'b1);
        wait_drain();
        rd(2'd0, 4'hE, "reg_r0_or");
        rd(2'd3, 4'hC, "reg_r3_xor");

        // ---- debug read old/new around WB, back-to-back accept ----
        dbg_addr = 2'd1;
        send(mk(3'b000, 2'd1, 2'd2, 2'd0, 1'b1, 4'h1, 4'h7), 1'b1);   // r1 = 6 + 1
        @(negedge clk);                                               // EXEC
        @(negedge clk);                                               // WB
        #1 chk("dbg_old_in_wb", dbg_data, 4'hA);
        set_fields(mk(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 4'h0, 4'h0));   // r2 = r1 + 0
        instr_valid = 1'b1;
        e.data = 4'h7; e.dst = 2'd2; e.acc = cyc + 2;
        q.push_back(e);
        @(negedge clk);                                               // res_valid cycle
        #1;
        chk("dbg_new_after_wb", dbg_data, 4'h7);
        chk("ready_with_res_valid", instr_ready, 1'b1);
        chk("abop_held", {A, B, Op}, {4'h6, 4'h1, 3'b000});
        @(posedge clk);
        #1 instr_valid = 1'b0;
        wait_drain();
        rd(2'd2, 4'h7, "reg_r2_fresh");

        // ---- reset dominates a simultaneous handshake ----
        @(negedge clk);
        rst = 1'b1;
        set_fields(mk(3'b000, 2'd0, 2'd1, 2'd0, 1'b1, 4'h1, 4'h0));
        instr_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_dom_ready", instr_ready, 1'b1);
        chk("rst_dom_A", A, 4'h0);
        rd(2'd1, 4'h0, "rst_dom_reg");

        // ---- reset in EXEC aborts ----
        send(mk(3'b000, 2'd1, 2'd3, 2'd0, 1'b1, 4'h3, 4'h3), 1'b1);
        wait_drain();
        rd(2'd1, 4'h3, "reg_r1_pre_abort");
        send(mk(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 4'h1, 4'h4), 1'b0);   // now in EXEC
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", instr_ready, 1'b1);
        for (int i = 0; i < 4; i++) rd(i[1:0], 4'h0, "abort_reg");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_res_valid", res_valid, 1'b0);
        end

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
